// File: rtl/ggt_pkg.sv
// Shared defaults and state type for the GCD request scheduler.
package ggt_pkg;

  localparam int GGT_W       = 16;
  localparam int GGT_N_REQ   = 4;
  localparam int GGT_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    WAIT,
    DONE
  } ggt_sched_state_t;

endpackage

// File: rtl/ggt_sched_if.sv
// Requester-side bundle of the GCD scheduler: per-requester request levels,
// packed operand pairs, and the one-hot grant/completion returns with result.
interface ggt_sched_if
  import ggt_pkg::*;
#(
  parameter int N_REQ = GGT_N_REQ,
  parameter int W     = GGT_W
);

  logic [N_REQ-1:0]   req_i;
  logic [N_REQ*W-1:0] zahl1_i;
  logic [N_REQ*W-1:0] zahl2_i;
  logic [N_REQ-1:0]   gnt_o;
  logic [N_REQ-1:0]   done_o;
  logic [W-1:0]       ergebnis_o;
  logic               err_o;

  modport master (
    output req_i, zahl1_i, zahl2_i,
    input  gnt_o, done_o, ergebnis_o, err_o
  );

  modport slave (
    input  req_i, zahl1_i, zahl2_i,
    output gnt_o, done_o, ergebnis_o, err_o
  );

endinterface

// File: rtl/ggt_rr_arbiter.sv
// Combinational round-robin pick: the first active request at or after ptr
// (wrapping) wins. The pointer itself is owned by the scheduler.
module ggt_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW:0] cand;

  // Walk the requesters starting at ptr and take the first one that asks.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IW + 1)'(i);
      if (cand >= (IW + 1)'(N_REQ)) begin
        cand = cand - (IW + 1)'(N_REQ);
      end
      if (!any && req[cand[IW-1:0]]) begin
        gnt[cand[IW-1:0]] = 1'b1;
        idx               = cand[IW-1:0];
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ggt_sched.sv
// Round-robin scheduler sharing one Euclid GCD core among several requesters.
// Zero operands are answered without the core; a watchdog bounds the wait.
module ggt_sched
  import ggt_pkg::*;
#(
  parameter int N_REQ   = GGT_N_REQ,
  parameter int W       = GGT_W,
  parameter int TIMEOUT = GGT_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  ggt_sched_if.slave   req_if,
  output logic         busy_o,
  output logic         core_start_o,
  output logic [W-1:0] core_zahl1_o,
  output logic [W-1:0] core_zahl2_o,
  input  logic [W-1:0] core_ergebnis_i,
  input  logic         core_valid_i
);

  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IW-1:0]  LAST_ID = IW'(N_REQ - 1);

  ggt_sched_state_t state, state_n;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    id;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic [W-1:0]     pick_a;
  logic [W-1:0]     pick_b;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic [W-1:0]     result;
  logic             err;
  logic [WDW-1:0]   wdog;
  logic             wd_expired;

  ggt_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req (req_if.req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_a     = req_if.zahl1_i[int'(pick_idx) * W +: W];
  assign pick_b     = req_if.zahl2_i[int'(pick_idx) * W +: W];
  assign wd_expired = (wdog == WD_LAST);

  // State register; reset drops any in-flight job without a completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus the grant and done pulses. Grant is held off while rst
  // is high so a request waiting through reset is not shown a grant early.
  always_comb begin
    state_n = state;
    gnt     = '0;
    done    = '0;
    unique case (state)
      IDLE: begin
        if (pick_any && !rst) begin
          gnt     = pick_gnt;
          state_n = (pick_a == '0 || pick_b == '0) ? DONE : START;
        end
      end
      START:   state_n = ARM;
      ARM:     state_n = WAIT;
      WAIT: begin
        if (core_valid_i || wd_expired) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done[id] = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Job bookkeeping: operand capture, pointer advance, watchdog and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      id           <= '0;
      core_zahl1_o <= '0;
      core_zahl2_o <= '0;
      result       <= '0;
      err          <= 1'b0;
      wdog         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            id           <= pick_idx;
            core_zahl1_o <= pick_a;
            core_zahl2_o <= pick_b;
            ptr          <= (pick_idx == LAST_ID) ? '0 : pick_idx + IW'(1);
            err          <= 1'b0;
            if (pick_a == '0) begin
              result <= pick_b;
            end else if (pick_b == '0) begin
              result <= pick_a;
            end
          end
        end
        ARM: wdog <= '0;
        WAIT: begin
          if (core_valid_i) begin
            result <= core_ergebnis_i;
          end else if (wd_expired) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_if.gnt_o      = gnt;
  assign req_if.done_o     = done;
  assign req_if.ergebnis_o = result;
  assign req_if.err_o      = err && (state == DONE);
  assign busy_o            = (state != IDLE);
  assign core_start_o      = (state == START);

endmodule

// File: tb/tb_ggt_sched.sv
// Directed bench for ggt_sched with a behavioural Euclid core that can answer
// normally, hold valid high between jobs, or never answer.
module tb_ggt_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  typedef struct {
    int           cyc;
    logic [N-1:0] vec;
    logic [W-1:0] res;
    logic         err;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         busy;
  logic         core_start;
  logic [W-1:0] core_z1;
  logic [W-1:0] core_z2;
  logic [W-1:0] core_res;
  logic         core_valid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int core_mode = 0;
  int issued  [N] = '{default: 0};
  int granted [N] = '{default: 0};

  ev_t gq[$];
  ev_t dq[$];
  int  sq[$];

  logic [W-1:0] ca;
  logic [W-1:0] cb;
  logic         cbusy;
  logic [N-1:0] gseen;

  ggt_sched_if #(.N_REQ(N), .W(W)) bus ();

  ggt_sched #(
    .N_REQ   (N),
    .W       (W),
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_if          (bus),
    .busy_o          (busy),
    .core_start_o    (core_start),
    .core_zahl1_o    (core_z1),
    .core_zahl2_o    (core_z2),
    .core_ergebnis_i (core_res),
    .core_valid_i    (core_valid)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // A requester holds its request until the edge that captures its grant.
  always_comb begin
    bus.req_i = '0;
    for (int k = 0; k < N; k++) bus.req_i[k] = (issued[k] != granted[k]);
  end

  // Retire a granted request just after the capturing clock edge.
  always @(negedge clk) begin
    if (bus.gnt_o != '0) begin
      gseen = bus.gnt_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (gseen[k]) granted[k]++;
    end
  end

  // Record grants, completions and core starts mid-cycle.
  always @(negedge clk) begin
    ev_t e;
    e.cyc = cyc;
    e.res = bus.ergebnis_o;
    e.err = bus.err_o;
    if (bus.gnt_o != '0) begin
      e.vec = bus.gnt_o;
      gq.push_back(e);
    end
    if (bus.done_o != '0) begin
      e.vec = bus.done_o;
      dq.push_back(e);
    end
    if (core_start) sq.push_back(cyc);
  end

  // Euclid core model: one modulo step per cycle. Mode 0 pulses valid,
  // mode 1 keeps valid and the old result up until the first step of the
  // next job, mode 2 never answers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_valid <= 1'b0;
      core_res   <= '0;
      ca         <= '0;
      cb         <= '0;
      cbusy      <= 1'b0;
    end else if (core_start) begin
      ca    <= core_z1;
      cb    <= core_z2;
      cbusy <= 1'b1;
      if (core_mode != 1) core_valid <= 1'b0;
    end else if (cbusy) begin
      core_valid <= 1'b0;
      if (cb == '0) begin
        cbusy <= 1'b0;
        if (core_mode != 2) begin
          core_valid <= 1'b1;
          core_res   <= ca;
        end
      end else begin
        ca <= cb;
        cb <= ca % cb;
      end
    end else if (core_mode != 1) begin
      core_valid <= 1'b0;
    end
  end

  task automatic applyStimulus(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.zahl1_i[k*W +: W] = a;
    bus.zahl2_i[k*W +: W] = b;
    issued[k]++;
  endtask

  task automatic wait_dones(input int n, input int maxc, output bit ok);
    int c = 0;
    while (dq.size() < n && c < maxc) begin
      @(posedge clk);
      c++;
    end
    ok = (dq.size() >= n);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(0, 16'd48, 16'd18);
    applyStimulus(1, 16'd24255, 16'd12540);
    applyStimulus(2, 16'd7, 16'd13);
    applyStimulus(3, 16'd100, 16'd75);
    @(negedge clk);
    checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.gnt_o); end
    checks++; if (bus.done_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0000", bus.done_o); end
    checks++; if (bus.ergebnis_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_ergebnis: got %0d expected 0", bus.ergebnis_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b expected 0", core_start); end
    checks++; if (core_z1 !== 16'd0) begin errors++; $display("[TB] FAIL reset_zahl1: got %0d expected 0", core_z1); end
    checks++; if (core_z2 !== 16'd0) begin errors++; $display("[TB] FAIL reset_zahl2: got %0d expected 0", core_z2); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_res [N] = '{16'd6, 16'd165, 16'd1, 16'd25};
    logic [N-1:0] ev;
    bit ok;
    int g0 = gq.size();
    int d0 = dq.size();
    int s0 = sq.size();
    wait_dones(d0 + 4, 300, ok);
    checks++;
    if (!ok || gq.size() < g0 + 4 || sq.size() <= s0) begin
      errors++;
      $display("[TB] FAIL rr_complete: got %0d dones expected %0d", dq.size() - d0, 4);
      return;
    end
    checks++; if (sq[s0] !== gq[g0].cyc + 1) begin errors++; $display("[TB] FAIL rr_start_cycle: got %0d expected %0d", sq[s0], gq[g0].cyc + 1); end
    for (int i = 0; i < N; i++) begin
      ev = 4'b0001 << i;
      checks++; if (gq[g0+i].vec !== ev) begin errors++; $display("[TB] FAIL rr_gnt%0d: got %b expected %b", i, gq[g0+i].vec, ev); end
      checks++; if (dq[d0+i].vec !== ev) begin errors++; $display("[TB] FAIL rr_done%0d: got %b expected %b", i, dq[d0+i].vec, ev); end
      checks++; if (dq[d0+i].res !== exp_res[i]) begin errors++; $display("[TB] FAIL rr_res%0d: got %0d expected %0d", i, dq[d0+i].res, exp_res[i]); end
      checks++; if (dq[d0+i].err !== 1'b0) begin errors++; $display("[TB] FAIL rr_err%0d: got %b expected 0", i, dq[d0+i].err); end
    end
    for (int i = 0; i < N - 1; i++) begin
      checks++; if (gq[g0+i+1].cyc !== dq[d0+i].cyc + 1) begin errors++; $display("[TB] FAIL rr_b2b%0d: got cycle %0d expected %0d", i, gq[g0+i+1].cyc, dq[d0+i].cyc + 1); end
    end
  endtask

  task automatic test_single();
    bit ok;
    int g0 = gq.size();
    int d0 = dq.size();
    int s0 = sq.size();
    applyStimulus(0, 16'd24255, 16'd12540);
    wait_dones(d0 + 1, 60, ok);
    checks++;
    if (!ok || gq.size() != g0 + 1) begin
      errors++;
      $display("[TB] FAIL single_complete: got %0d grants expected 1", gq.size() - g0);
      return;
    end
    checks++; if (gq[g0].vec !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 0001", gq[g0].vec); end
    checks++; if (sq.size() !== s0 + 1) begin errors++; $display("[TB] FAIL single_start_count: got %0d expected 1", sq.size() - s0); end
    else begin
      checks++; if (sq[s0] !== gq[g0].cyc + 1) begin errors++; $display("[TB] FAIL single_start_cycle: got %0d expected %0d", sq[s0], gq[g0].cyc + 1); end
    end
    checks++; if (dq[d0].vec !== 4'b0001) begin errors++; $display("[TB] FAIL single_done: got %b expected 0001", dq[d0].vec); end
    checks++; if (dq[d0].res !== 16'd165) begin errors++; $display("[TB] FAIL single_res: got %0d expected 165", dq[d0].res); end
    checks++; if (dq[d0].err !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b expected 0", dq[d0].err); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] exp_res [3] = '{16'd9, 16'd35, 16'd0};
    logic [N-1:0] ev;
    bit ok;
    int g0 = gq.size();
    int d0 = dq.size();
    int s0 = sq.size();
    applyStimulus(1, 16'd9, 16'd0);
    applyStimulus(2, 16'd0, 16'd35);
    applyStimulus(3, 16'd0, 16'd0);
    wait_dones(d0 + 3, 40, ok);
    checks++;
    if (!ok || gq.size() < g0 + 3) begin
      errors++;
      $display("[TB] FAIL bypass_complete: got %0d dones expected 3", dq.size() - d0);
      return;
    end
    for (int i = 0; i < 3; i++) begin
      ev = 4'b0010 << i;
      checks++; if (dq[d0+i].vec !== ev) begin errors++; $display("[TB] FAIL bypass_done%0d: got %b expected %b", i, dq[d0+i].vec, ev); end
      checks++; if (dq[d0+i].res !== exp_res[i]) begin errors++; $display("[TB] FAIL bypass_res%0d: got %0d expected %0d", i, dq[d0+i].res, exp_res[i]); end
      checks++; if (dq[d0+i].cyc !== gq[g0+i].cyc + 1) begin errors++; $display("[TB] FAIL bypass_lat%0d: got cycle %0d expected %0d", i, dq[d0+i].cyc, gq[g0+i].cyc + 1); end
    end
    checks++; if (gq[g0+1].cyc !== gq[g0].cyc + 2) begin errors++; $display("[TB] FAIL bypass_next_gnt: got cycle %0d expected %0d", gq[g0+1].cyc, gq[g0].cyc + 2); end
    checks++; if (sq.size() !== s0) begin errors++; $display("[TB] FAIL bypass_no_start: got %0d starts expected 0", sq.size() - s0); end
  endtask

  task automatic test_timeout();
    bit ok;
    int g0 = gq.size();
    int d0 = dq.size();
    core_mode = 2;
    applyStimulus(1, 16'd12, 16'd8);
    wait_dones(d0 + 1, 40, ok);
    checks++;
    if (!ok || gq.size() != g0 + 1) begin
      errors++;
      $display("[TB] FAIL timeout_complete: got %0d dones expected 1", dq.size() - d0);
      return;
    end
    checks++; if (dq[d0].vec !== 4'b0010) begin errors++; $display("[TB] FAIL timeout_done: got %b expected 0010", dq[d0].vec); end
    checks++; if (dq[d0].cyc !== gq[g0].cyc + 3 + TO) begin errors++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", dq[d0].cyc, gq[g0].cyc + 3 + TO); end
    checks++; if (dq[d0].err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", dq[d0].err); end
    checks++; if (dq[d0].res !== 16'd0) begin errors++; $display("[TB] FAIL timeout_res: got %0d expected 0", dq[d0].res); end
    core_mode = 0;
    applyStimulus(3, 16'd21, 16'd14);
    wait_dones(d0 + 2, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL after_timeout_complete: got %0d dones expected 2", dq.size() - d0);
      return;
    end
    checks++; if (dq[d0+1].vec !== 4'b1000) begin errors++; $display("[TB] FAIL after_timeout_done: got %b expected 1000", dq[d0+1].vec); end
    checks++; if (dq[d0+1].res !== 16'd7) begin errors++; $display("[TB] FAIL after_timeout_res: got %0d expected 7", dq[d0+1].res); end
    checks++; if (dq[d0+1].err !== 1'b0) begin errors++; $display("[TB] FAIL after_timeout_err: got %b expected 0", dq[d0+1].err); end
  endtask

  task automatic test_stale_valid();
    bit ok;
    int d0 = dq.size();
    int g1;
    core_mode = 1;
    applyStimulus(0, 16'd100, 16'd75);
    wait_dones(d0 + 1, 40, ok);
    checks++;
    if (!ok || dq[d0].res !== 16'd25) begin
      errors++;
      $display("[TB] FAIL stale_first_res: got %0d expected 25", ok ? dq[d0].res : 16'd0);
      return;
    end
    g1 = gq.size();
    applyStimulus(1, 16'd48, 16'd18);
    wait_dones(d0 + 2, 40, ok);
    checks++;
    if (!ok || gq.size() <= g1) begin
      errors++;
      $display("[TB] FAIL stale_complete: got %0d dones expected 2", dq.size() - d0);
      return;
    end
    checks++; if (dq[d0+1].res !== 16'd6) begin errors++; $display("[TB] FAIL stale_res: got %0d expected 6", dq[d0+1].res); end
    checks++; if (dq[d0+1].err !== 1'b0) begin errors++; $display("[TB] FAIL stale_err: got %b expected 0", dq[d0+1].err); end
    checks++; if (dq[d0+1].cyc < gq[g1].cyc + 4) begin errors++; $display("[TB] FAIL stale_early: got cycle %0d expected at least %0d", dq[d0+1].cyc, gq[g1].cyc + 4); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int c = 0;
    int g0 = gq.size();
    int d0 = dq.size();
    int g1;
    int d1;
    int rel;
    int bad;
    core_mode = 2;
    applyStimulus(2, 16'd30, 16'd12);
    while (gq.size() == g0 && c < 20) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (gq.size() == g0) begin
      errors++;
      $display("[TB] FAIL rstwait_gnt: got no grant expected 0100");
      return;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_busy_before: got %b expected 1", busy); end
    applyStimulus(1, 16'd9, 16'd6);
    applyStimulus(3, 16'd40, 16'd25);
    core_mode = 0;
    rst = 1'b1;
    #1;
    checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("[TB] FAIL rstwait_gnt0: got %b expected 0000", bus.gnt_o); end
    checks++; if (bus.done_o !== 4'b0000) begin errors++; $display("[TB] FAIL rstwait_done0: got %b expected 0000", bus.done_o); end
    checks++; if (bus.ergebnis_o !== 16'd0) begin errors++; $display("[TB] FAIL rstwait_ergebnis0: got %0d expected 0", bus.ergebnis_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_busy0: got %b expected 0", busy); end
    checks++; if (core_z1 !== 16'd0) begin errors++; $display("[TB] FAIL rstwait_zahl1: got %0d expected 0", core_z1); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_start0: got %b expected 0", core_start); end
    repeat (2) @(posedge clk);
    #1;
    g1  = gq.size();
    d1  = dq.size();
    rel = cyc;
    rst = 1'b0;
    wait_dones(d1 + 2, 60, ok);
    checks++;
    if (!ok || gq.size() < g1 + 2) begin
      errors++;
      $display("[TB] FAIL rstwait_complete: got %0d dones expected 2", dq.size() - d1);
      return;
    end
    checks++; if (gq[g1].vec !== 4'b0010) begin errors++; $display("[TB] FAIL rstwait_first_gnt: got %b expected 0010", gq[g1].vec); end
    checks++; if (gq[g1].cyc !== rel) begin errors++; $display("[TB] FAIL rstwait_gnt_cycle: got %0d expected %0d", gq[g1].cyc, rel); end
    checks++; if (dq[d1].res !== 16'd3) begin errors++; $display("[TB] FAIL rstwait_res1: got %0d expected 3", dq[d1].res); end
    checks++; if (dq[d1+1].vec !== 4'b1000 || dq[d1+1].res !== 16'd5) begin errors++; $display("[TB] FAIL rstwait_res3: got %b/%0d expected 1000/5", dq[d1+1].vec, dq[d1+1].res); end
    bad = 0;
    for (int i = d0; i < dq.size(); i++) if (dq[i].vec[2]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rstwait_aborted_done: got %0d expected 0", bad); end
  endtask

  initial begin
    bus.zahl1_i = '0;
    bus.zahl2_i = '0;
    $display("[TB] ggt_sched directed bench");
    test_reset();
    test_round_robin();
    test_single();
    test_bypass();
    test_timeout();
    test_stale_valid();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ggt_sched.md
# ggt_sched

Round-robin scheduler sharing one Euclid GCD core (`ggt_top` interface: start pulse, two 16-bit operands, `ergebnis`, `valid`) among `N_REQ` requesters. Captures one operand pair per grant, sequences the core's start/valid handshake, and returns the result to the granted requester. Zero operands bypass the core, and a watchdog bounds the wait so a stalled core cannot lock out the other requesters. Sits between the requester ports and a single `ggt_top` instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 16: operand/result width.
- `TIMEOUT`, 65535: max cycles in WAIT before error completion (≥4).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; asynchronous and active-high.
- `req_i` in N_REQ: per-requester request level; held with operands until `gnt_o[k]`.
- `zahl1_i` in N_REQ*W: packed operand 1, slice k = requester k.
- `zahl2_i` in N_REQ*W: packed operand 2.
- `gnt_o` out N_REQ: one-hot, one-cycle pulse; operands of k captured this cycle.
- `done_o` out N_REQ: one-hot, one-cycle completion pulse.
- `ergebnis_o` out W: result, valid while `done_o` != 0, held otherwise.
- `err_o` out 1: timeout flag, qualified by `done_o`.
- `busy_o` out 1: high in every state except IDLE.
- `core_start_o` out 1: start pulse to core.
- `core_zahl1_o`, `core_zahl2_o` out W: registered operands to core, stable START..WAIT.
- `core_ergebnis_i` in W, `core_valid_i` in 1: core result/valid.

## Operation
- States: IDLE, START, ARM, WAIT, DONE.
- IDLE: if any `req_i`, round-robin pick starting at `ptr`; pulse `gnt_o[k]`, capture operands and id k, set `ptr` = k+1 mod N_REQ. If either operand is 0 go to DONE with result = other operand (0,0 -> 0), else START.
- START: `core_start_o`=1 for exactly one cycle -> ARM.
- ARM: one cycle, `core_valid_i` ignored (stale valid from previous job) -> WAIT; watchdog cleared.
- WAIT: on `core_valid_i`=1 capture `core_ergebnis_i` -> DONE; else increment watchdog; at count == TIMEOUT-1 -> DONE with result 0, err=1.
- DONE: `done_o[id]`=1, `ergebnis_o`/`err_o` driven -> IDLE. No grant in DONE.
- Requests deasserted before grant are simply not served; `req_i` re-asserted by k in its own DONE cycle is arbitrated normally in the following IDLE.
- Operands/results unsigned W bits; no arithmetic in this block beyond zero detection and watchdog count (width clog2(TIMEOUT+1)).

## Timing
- Reset (async): state IDLE, `ptr`=0, all outputs 0 (`gnt_o`, `done_o`, `ergebnis_o`, `err_o`, `busy_o`, `core_*_o`); in-flight job discarded, no done issued.
- Core path: gnt at T, `core_start_o` at T+1, ARM T+2, WAIT from T+3; `core_valid_i` first sampled at V ≥ T+3 -> `done_o` at V+1; next gnt earliest V+2.
- Bypass: gnt at T, `done_o` at T+1, next gnt at T+2.
- Timeout: `done_o`+`err_o` at T+3+TIMEOUT; late core valid afterwards ignored (next job passes through ARM).
- Fairness: with all requesters continuously requesting, grants cycle 0,1,…,N_REQ-1,0.

## Structure
- Package `ggt_pkg`: W default, state enum `ggt_sched_state_t`, TIMEOUT default.
- Sub-module `ggt_rr_arbiter`: combinational round-robin pick (req vector + ptr -> one-hot grant + index); pointer register stays in `ggt_sched`.

## Test plan
- Requester 0: 24255, 12540 with real `ggt_top` -> `done_o`=0001, `ergebnis_o`=165, `err_o`=0, start exactly one cycle after gnt.
- All 4 request simultaneously (48/18, 24255/12540, 7/13, 100/75) -> grants 0,1,2,3 in order; results 6, 165, 1, 25 on matching `done_o` bits.
- Requester 2: 0, 35 -> `done_o[2]` one cycle after gnt, result 35, `core_start_o` never asserted; 0,0 -> result 0.
- Core model never asserts valid, TIMEOUT=8 -> `done_o` at T+11 with `err_o`=1, result 0; next request then served normally.
- Core model holds `valid` high from previous job through next start -> result taken only from WAIT, not from stale valid.
- Assert `rst` in WAIT -> all outputs 0 immediately; no done for aborted job; held request re-granted after reset release, `ptr`=0.
